// File: rtl/bram_pkg.sv
// Shared constants and helpers for the byte-enabled simple dual-port RAM.
package bram_pkg;

   localparam int RW_READ_FIRST  = 0;
   localparam int RW_WRITE_FIRST = 1;

   // Widest word the byte-merge helper handles; callers zero-extend into it.
   localparam int MAX_DW = 256;

   function automatic bit latency_ok(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction

   // Bit b comes from new_w when the lane covering it (b / bw) is enabled.
   function automatic logic [MAX_DW-1:0] merge_be(input logic [MAX_DW-1:0] old_w,
                                                  input logic [MAX_DW-1:0] new_w,
                                                  input logic [MAX_DW-1:0] be,
                                                  input int                bw);
      logic [MAX_DW-1:0] r;
      r = old_w;
      for (int b = 0; b < MAX_DW; b++) begin
         if (be[b / bw]) r[b] = new_w[b];
      end
      return r;
   endfunction

endpackage

// File: rtl/bram_sdp_be_pipelined_if.sv
// Write/read port bundle of the simple dual-port RAM.
interface bram_sdp_be_pipelined_if #(
   parameter int addr_width = 10,
   parameter int data_width = 32,
   parameter int byte_width = 8
);
   localparam int nb = data_width / byte_width;

   logic                  we;
   logic [nb-1:0]         wbe;
   logic [addr_width-1:0] addr_w;
   logic [data_width-1:0] din;
   logic                  re;
   logic [addr_width-1:0] addr_r;
   logic [data_width-1:0] dout;
   logic                  dout_valid;

   modport master (output we, wbe, addr_w, din, re, addr_r,
                   input  dout, dout_valid);
   modport slave  (input  we, wbe, addr_w, din, re, addr_r,
                   output dout, dout_valid);
endinterface

// File: rtl/bram_rd_pipe.sv
// Read valid/data pipeline (1 or 2 stages) with the write-first collision bypass.
module bram_rd_pipe
   import bram_pkg::*;
#(
   parameter int data_width   = 32,
   parameter int byte_width   = 8,
   parameter int read_latency = 1,
   parameter int rw_mode      = RW_READ_FIRST,
   localparam int nb          = data_width / byte_width
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  re,
   input  logic                  we,
   input  logic [nb-1:0]         wbe,
   input  logic [data_width-1:0] din,
   input  logic                  addr_hit,
   input  logic [data_width-1:0] rd_word,
   output logic [data_width-1:0] dout,
   output logic                  dout_valid
);

   logic                  s1_valid_d;
   logic [data_width-1:0] s1_data_d;
   logic                  stg_valid;
   logic [data_width-1:0] stg_data;
   logic [data_width-1:0] dout_d, dout_q;
   logic                  dout_valid_q;

   // rd_word is the pre-write array word, so read-first needs no bypass at all.
   always_comb begin
      s1_valid_d = re;
      s1_data_d  = rd_word;
      if (rw_mode == RW_WRITE_FIRST && we && addr_hit) begin
         s1_data_d = data_width'(merge_be(MAX_DW'(rd_word), MAX_DW'(din),
                                          MAX_DW'(wbe), byte_width));
      end
   end

   generate
      if (read_latency == 2) begin : g_lat2
         logic                  s1_valid_q;
         logic [data_width-1:0] s1_data_q;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               s1_valid_q <= 1'b0;
               s1_data_q  <= '0;
            end else begin
               s1_valid_q <= s1_valid_d;
               s1_data_q  <= s1_data_d;
            end
         end
         assign stg_valid = s1_valid_q;
         assign stg_data  = s1_data_q;
      end else begin : g_lat1
         assign stg_valid = s1_valid_d;
         assign stg_data  = s1_data_d;
      end
   endgenerate

   always_comb begin
      dout_d = dout_q;
      if (stg_valid) dout_d = stg_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         dout_q       <= dout_d;
         dout_valid_q <= stg_valid;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;

endmodule

// File: rtl/bram_sdp_be_pipelined.sv
// Byte-enabled simple dual-port block RAM: storage array and write port, read pipe below.
module bram_sdp_be_pipelined
   import bram_pkg::*;
#(
   parameter int addr_width   = 10,
   parameter int data_width   = 32,
   parameter int byte_width   = 8,
   parameter int read_latency = 1,
   parameter int rw_mode      = RW_READ_FIRST
) (
   input logic                   clk,
   input logic                   reset_n,
   bram_sdp_be_pipelined_if.slave bus
);

   localparam int nb = data_width / byte_width;

   generate
      if (data_width % byte_width != 0) begin : g_bad_bw
         $fatal(1, "data_width must be an integer multiple of byte_width");
      end
      if (!latency_ok(read_latency)) begin : g_bad_lat
         $fatal(1, "read_latency must be 1 or 2");
      end
      if (data_width > MAX_DW) begin : g_bad_dw
         $fatal(1, "data_width exceeds bram_pkg::MAX_DW");
      end
   endgenerate

   // No reset on the array so it maps onto block RAM; contents survive reset.
   logic [data_width-1:0] mem [2**addr_width];
   logic [data_width-1:0] rd_word;

   always_ff @(posedge clk) begin
      if (bus.we) begin
         for (int i = 0; i < nb; i++) begin
            if (bus.wbe[i]) mem[bus.addr_w][i*byte_width +: byte_width] <= bus.din[i*byte_width +: byte_width];
         end
      end
   end

   assign rd_word = mem[bus.addr_r];

   bram_rd_pipe #(
      .data_width   (data_width),
      .byte_width   (byte_width),
      .read_latency (read_latency),
      .rw_mode      (rw_mode)
   ) u_rd_pipe (
      .clk        (clk),
      .reset_n    (reset_n),
      .re         (bus.re),
      .we         (bus.we),
      .wbe        (bus.wbe),
      .din        (bus.din),
      .addr_hit   (bus.addr_w == bus.addr_r),
      .rd_word    (rd_word),
      .dout       (bus.dout),
      .dout_valid (bus.dout_valid)
   );

endmodule

// File: tb/tb_bram_sdp_be_pipelined.sv
// Directed bench: four RAM instances covering both read latencies and both collision modes.
module tb_bram_sdp_be_pipelined;

   logic clk;
   logic reset_n;
   int   n_err;
   int   n_chk;

   // bXY: X = latency-1, Y = rw_mode
   bram_sdp_be_pipelined_if #(.addr_width(10), .data_width(32), .byte_width(8)) b00 ();
   bram_sdp_be_pipelined_if #(.addr_width(10), .data_width(32), .byte_width(8)) b01 ();
   bram_sdp_be_pipelined_if #(.addr_width(10), .data_width(32), .byte_width(8)) b10 ();
   bram_sdp_be_pipelined_if #(.addr_width(10), .data_width(32), .byte_width(8)) b11 ();

   bram_sdp_be_pipelined #(.addr_width(10), .data_width(32), .byte_width(8), .read_latency(1), .rw_mode(0))
      u00 (.clk(clk), .reset_n(reset_n), .bus(b00.slave));
   bram_sdp_be_pipelined #(.addr_width(10), .data_width(32), .byte_width(8), .read_latency(1), .rw_mode(1))
      u01 (.clk(clk), .reset_n(reset_n), .bus(b01.slave));
   bram_sdp_be_pipelined #(.addr_width(10), .data_width(32), .byte_width(8), .read_latency(2), .rw_mode(0))
      u10 (.clk(clk), .reset_n(reset_n), .bus(b10.slave));
   bram_sdp_be_pipelined #(.addr_width(10), .data_width(32), .byte_width(8), .read_latency(2), .rw_mode(1))
      u11 (.clk(clk), .reset_n(reset_n), .bus(b11.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic [3:0] be, input logic [9:0] aw,
                        input logic [31:0] d, input logic r, input logic [9:0] ar);
      b00.we = w; b00.wbe = be; b00.addr_w = aw; b00.din = d; b00.re = r; b00.addr_r = ar;
      b01.we = w; b01.wbe = be; b01.addr_w = aw; b01.din = d; b01.re = r; b01.addr_r = ar;
      b10.we = w; b10.wbe = be; b10.addr_w = aw; b10.din = d; b10.re = r; b10.addr_r = ar;
      b11.we = w; b11.wbe = be; b11.addr_w = aw; b11.din = d; b11.re = r; b11.addr_r = ar;
   endtask

   task automatic idle();
      drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
   endtask

   task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
      drive(1'b1, be, a, d, 1'b0, 10'd0);
      step();
      idle();
   endtask

   // One read (optionally with a same-cycle write); e0/e1 are expected for rw_mode 0/1.
   task automatic read_chk(input string tag, input logic [9:0] a,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic cw, input logic [3:0] cbe, input logic [31:0] cd);
      drive(cw, cbe, a, cd, 1'b1, a);
      step();
      idle();
      chkb({tag, " l1m0 valid@1"}, b00.dout_valid, 1'b1);
      chk ({tag, " l1m0 dout@1"},  b00.dout, e0);
      chkb({tag, " l1m1 valid@1"}, b01.dout_valid, 1'b1);
      chk ({tag, " l1m1 dout@1"},  b01.dout, e1);
      chkb({tag, " l2m0 valid@1"}, b10.dout_valid, 1'b0);
      chkb({tag, " l2m1 valid@1"}, b11.dout_valid, 1'b0);
      step();
      chkb({tag, " l1m0 valid@2"}, b00.dout_valid, 1'b0);
      chk ({tag, " l1m0 hold@2"},  b00.dout, e0);
      chkb({tag, " l1m1 valid@2"}, b01.dout_valid, 1'b0);
      chk ({tag, " l1m1 hold@2"},  b01.dout, e1);
      chkb({tag, " l2m0 valid@2"}, b10.dout_valid, 1'b1);
      chk ({tag, " l2m0 dout@2"},  b10.dout, e0);
      chkb({tag, " l2m1 valid@2"}, b11.dout_valid, 1'b1);
      chk ({tag, " l2m1 dout@2"},  b11.dout, e1);
      step();
      chkb({tag, " l2m0 valid@3"}, b10.dout_valid, 1'b0);
      chk ({tag, " l2m0 hold@3"},  b10.dout, e0);
      chkb({tag, " l2m1 valid@3"}, b11.dout_valid, 1'b0);
      chk ({tag, " l2m1 hold@3"},  b11.dout, e1);
   endtask

   initial begin
      n_err   = 0;
      n_chk   = 0;
      reset_n = 1'b0;
      idle();
      repeat (3) step();
      reset_n = 1'b1;
      chk ("rst l1m0 dout",  b00.dout, 32'h0);
      chkb("rst l1m0 valid", b00.dout_valid, 1'b0);
      chk ("rst l2m1 dout",  b11.dout, 32'h0);
      chkb("rst l2m1 valid", b11.dout_valid, 1'b0);
      repeat (3) step();
      chkb("idle l1m0 valid", b00.dout_valid, 1'b0);
      chkb("idle l1m1 valid", b01.dout_valid, 1'b0);
      chkb("idle l2m0 valid", b10.dout_valid, 1'b0);
      chkb("idle l2m1 valid", b11.dout_valid, 1'b0);
      chk ("idle l2m0 dout",  b10.dout, 32'h0);

      // Byte-enable merge: lanes 0 and 2 overwritten
      wr(10'd5, 32'hAABBCCDD, 4'hF);
      wr(10'd5, 32'h11223344, 4'b0101);
      read_chk("be", 10'd5, 32'hAA22CC44, 32'hAA22CC44, 1'b0, 4'h0, 32'h0);

      // Streaming 0..15 back to back
      for (int i = 0; i < 16; i++) wr(10'(i), 32'(i), 4'hF);
      for (int k = 0; k < 16; k++) begin
         drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'(k));
         step();
         chkb("stream l1m0 valid", b00.dout_valid, 1'b1);
         chk ("stream l1m0 dout",  b00.dout, 32'(k));
         chkb("stream l1m1 valid", b01.dout_valid, 1'b1);
         chk ("stream l1m1 dout",  b01.dout, 32'(k));
         if (k > 0) begin
            chkb("stream l2m0 valid", b10.dout_valid, 1'b1);
            chk ("stream l2m0 dout",  b10.dout, 32'(k - 1));
            chkb("stream l2m1 valid", b11.dout_valid, 1'b1);
            chk ("stream l2m1 dout",  b11.dout, 32'(k - 1));
         end else begin
            chkb("stream l2m0 first", b10.dout_valid, 1'b0);
         end
      end
      idle();
      step();
      chkb("stream l1m0 end",    b00.dout_valid, 1'b0);
      chkb("stream l2m0 last v", b10.dout_valid, 1'b1);
      chk ("stream l2m0 last d", b10.dout, 32'd15);
      chk ("stream l2m1 last d", b11.dout, 32'd15);
      step();
      chkb("stream l2m0 end", b10.dout_valid, 1'b0);
      chkb("stream l2m1 end", b11.dout_valid, 1'b0);

      // Collision on addr 7, then the follow-up read and a wbe=0 no-op write
      wr(10'd7, 32'h0, 4'hF);
      read_chk("coll", 10'd7, 32'h00000000, 32'h0000BEEF, 1'b1, 4'b0011, 32'hDEADBEEF);
      read_chk("after", 10'd7, 32'h0000BEEF, 32'h0000BEEF, 1'b0, 4'h0, 32'h0);
      wr(10'd7, 32'hFFFFFFFF, 4'h0);
      read_chk("noop", 10'd7, 32'h0000BEEF, 32'h0000BEEF, 1'b0, 4'h0, 32'h0);

      // Reset pulse while the read is in flight
      drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd5);
      step();
      idle();
      reset_n = 1'b0;
      #2;
      chk ("midrst l1m0 dout",  b00.dout, 32'h0);
      chkb("midrst l1m0 valid", b00.dout_valid, 1'b0);
      chk ("midrst l2m0 dout",  b10.dout, 32'h0);
      reset_n = 1'b1;
      step();
      chkb("midrst l2m0 valid", b10.dout_valid, 1'b0);
      chk ("midrst l2m0 dout2", b10.dout, 32'h0);
      chkb("midrst l2m1 valid", b11.dout_valid, 1'b0);
      chk ("midrst l2m1 dout2", b11.dout, 32'h0);
      read_chk("postrst", 10'd5, 32'd5, 32'd5, 1'b0, 4'h0, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
